// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: width derivation and ratio clamping.
package cic_pkg;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Worst-case bit growth is ORDER*log2(R*M) on top of the input width.
  function automatic int cic_acc_w(input int in_w, input int order,
                                   input int r_max, input int diff_m);
    return in_w + order * clog2(r_max * diff_m);
  endfunction

  function automatic int clamp_ratio(input int r, input int r_max);
    if (r <= 1) return 1;
    else if (r > r_max) return r_max;
    else return r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: y = x - x delayed by DIFF_M valid samples, one register deep.
module cic_comb_stage #(
  parameter int ACC_W  = 42,
  parameter int DIFF_M = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data
);

  logic signed [ACC_W-1:0] in_s;
  logic signed [ACC_W-1:0] dly [DIFF_M];

  assign in_s = $signed(in_data);

  // Delay line only moves on valid samples so it counts strobes, not clocks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < DIFF_M; i++) dly[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= $unsigned(in_s - dly[DIFF_M-1]);
        dly[0]   <= in_s;
        for (int i = 1; i < DIFF_M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_decim_param.sv
// N-th order CIC decimator, single clock, runtime ratio changed on decimation
// boundaries only; combs are clocked by a strobe rather than a derived clock.
module cic_decim_param
  import cic_pkg::*;
#(
  parameter int IN_W   = 24,
  parameter int ORDER  = 3,
  parameter int R_MAX  = 64,
  parameter int DIFF_M = 1,
  parameter int ACC_W  = cic_acc_w(IN_W, ORDER, R_MAX, DIFF_M),
  parameter int OUT_W  = ACC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [IN_W-1:0]       xin,
  input  logic [clog2(R_MAX):0] dec_ratio,
  output logic [OUT_W-1:0]      yout,
  output logic                  yout_valid,
  output logic [clog2(R_MAX):0] ratio_active
);

  localparam int RW = clog2(R_MAX) + 1;

  logic signed [ACC_W-1:0] xin_ext;
  logic signed [ACC_W-1:0] integ [ORDER];
  logic [RW-1:0]           cnt;
  logic                    dec_stb;
  logic signed [ACC_W-1:0] comb_in_p0;
  logic                    vld_p0;
  logic [ACC_W-1:0]        comb_p [ORDER+1];
  logic                    vld_p  [ORDER+1];

  assign xin_ext = {{(ACC_W-IN_W){xin[IN_W-1]}}, xin};
  assign dec_stb = clk_enable && (cnt == ratio_active - RW'(1));

  // Integrator stage boundary: modular adders, wrap-around is intentional.
  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    logic signed [ACC_W-1:0] addend;
    if (k == 0) begin : g_first
      assign addend = xin_ext;
    end else begin : g_rest
      assign addend = integ[k-1];
    end
    always_ff @(posedge clk) begin
      if (!reset) integ[k] <= '0;
      else if (clk_enable) integ[k] <= integ[k] + addend;
    end
  end

  // Decimation boundary: capture last integrator and re-sample the ratio.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      ratio_active <= RW'(clamp_ratio(int'(dec_ratio), R_MAX));
      comb_in_p0   <= '0;
      vld_p0       <= 1'b0;
    end else begin
      vld_p0 <= dec_stb;
      if (clk_enable) cnt <= dec_stb ? '0 : cnt + RW'(1);
      if (dec_stb) begin
        comb_in_p0   <= integ[ORDER-1];
        ratio_active <= RW'(clamp_ratio(int'(dec_ratio), R_MAX));
      end
    end
  end

  assign comb_p[0] = $unsigned(comb_in_p0);
  assign vld_p[0]  = vld_p0;

  // Comb stage boundaries: one register per stage, never stalls.
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .ACC_W  (ACC_W),
      .DIFF_M (DIFF_M)
    ) u_comb (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vld_p[k]),
      .in_data   (comb_p[k]),
      .out_valid (vld_p[k+1]),
      .out_data  (comb_p[k+1])
    );
  end

  assign yout       = comb_p[ORDER][ACC_W-1 -: OUT_W];
  assign yout_valid = vld_p[ORDER];

endmodule

// File: tb/tb_cic_decim_param.sv
// Directed bench for cic_decim_param at default parameters (3rd order, R_MAX=64).
module tb_cic_decim_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [23:0] xin;
  logic [6:0]  dec_ratio;
  logic [41:0] yout;
  logic        yout_valid;
  logic [6:0]  ratio_active;

  int     checks = 0;
  int     failures = 0;
  int     cyc;
  int     nv;
  int     vc [64];
  longint vv [64];

  cic_decim_param dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .xin          (xin),
    .dec_ratio    (dec_ratio),
    .yout         (yout),
    .yout_valid   (yout_valid),
    .ratio_active (ratio_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and log any output pulse with the cycle it appeared in.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (yout_valid === 1'b1 && nv < 64) begin
      vc[nv] = cyc;
      vv[nv] = longint'($signed(yout));
      nv++;
    end
  endtask

  task automatic do_reset(input logic [6:0] ratio);
    reset      = 1'b0;
    dec_ratio  = ratio;
    clk_enable = 1'b1;
    xin        = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    cyc   = 0;
    nv    = 0;
    for (int i = 0; i < 64; i++) begin
      vc[i] = -1;
      vv[i] = -999;
    end
  endtask

  initial begin
    // Reset held three cycles with live input
    reset      = 1'b0;
    clk_enable = 1'b1;
    xin        = 24'd5;
    dec_ratio  = 7'd4;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_yout", longint'($signed(yout)), 0);
    check("rst_valid", longint'(yout_valid), 0);
    check("rst_ratio", longint'(ratio_active), 4);

    // DC gain R=4: outputs 1,32,63 transient then 64
    do_reset(7'd4);
    xin = 24'd1;
    repeat (24) step();
    check("dc_count", nv, 5);
    check("dc_first_cycle", vc[0], 7);
    check("dc_spacing", vc[1] - vc[0], 4);
    check("dc_y0", vv[0], 1);
    check("dc_y1", vv[1], 32);
    check("dc_y2", vv[2], 63);
    check("dc_y3", vv[3], 64);
    check("dc_y4", vv[4], 64);
    check("dc_hold_valid", longint'(yout_valid), 0);
    check("dc_hold_yout", longint'($signed(yout)), 64);

    // Impulse R=2, impulse on counter phase 0
    do_reset(7'd2);
    xin = 24'd1;
    step();
    xin = 24'd0;
    repeat (13) step();
    check("imp_a_cycle", vc[0], 5);
    check("imp_a_y0", vv[0], 0);
    check("imp_a_y1", vv[1], 1);
    check("imp_a_y2", vv[2], 3);
    check("imp_a_y3", vv[3], 0);
    check("imp_a_y4", vv[4], 0);

    // Impulse R=2, impulse on counter phase 1 picks up the other taps
    do_reset(7'd2);
    xin = 24'd0;
    step();
    xin = 24'd1;
    step();
    xin = 24'd0;
    repeat (12) step();
    check("imp_b_y1", vv[1], 0);
    check("imp_b_y2", vv[2], 3);
    check("imp_b_y3", vv[3], 1);
    check("imp_b_y4", vv[4], 0);

    // Wrap-around: most negative input at R=64 lands exactly on -2^41
    do_reset(7'd64);
    xin = 24'h800000;
    repeat (330) step();
    check("wrap_count", nv, 5);
    check("wrap_cycle3", vc[3], 259);
    check("wrap_y3", vv[3], -(longint'(1) << 41));
    check("wrap_y4", vv[4], -(longint'(1) << 41));

    // Clamp to 1: pass-through delayed by 7 cycles, valid every cycle
    do_reset(7'd0);
    check("clamp_lo", longint'(ratio_active), 1);
    for (int i = 0; i < 12; i++) begin
      xin = 24'(10 + cyc);
      step();
    end
    check("r1_count", nv, 9);
    check("r1_first_cycle", vc[0], 4);
    check("r1_last_cycle", vc[8], 12);
    check("r1_y0", vv[0], 0);
    check("r1_y3", vv[3], 10);
    check("r1_y5", vv[5], 12);
    check("r1_y8", vv[8], 15);

    // Ratio request only takes effect on a strobe
    dec_ratio  = 7'd200;
    clk_enable = 1'b0;
    step();
    step();
    check("ratio_hold", longint'(ratio_active), 1);
    clk_enable = 1'b1;
    step();
    check("clamp_hi", longint'(ratio_active), 64);

    // Gated enable R=4, then reset while a result is still in the combs
    do_reset(7'd4);
    xin = 24'd1;
    for (int i = 0; i < 40; i++) begin
      clk_enable = (cyc % 2 == 0);
      reset      = !(cyc == 31 || cyc == 32);
      step();
    end
    check("gate_count", nv, 3);
    check("gate_first_cycle", vc[0], 10);
    check("gate_spacing", vc[1] - vc[0], 8);
    check("gate_spacing2", vc[2] - vc[1], 8);
    check("gate_y0", vv[0], 1);
    check("gate_y1", vv[1], 32);
    check("gate_y2", vv[2], 63);
    check("gate_rst_yout", longint'($signed(yout)), 0);
    check("gate_rst_valid", longint'(yout_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
